odd_even_sorter: RTL and testbench



---
 rtl/odd_even_sorter.sv | 144 ++++++++++++++
 tb/tb_odd_even_sorter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_even_sorter.sv
// In-place odd-even transposition sorter of {key,tag} entries, one compare/swap phase per clock.
// Latency 2..K_NUMBERS phases after start; no backpressure, load/start only accepted while idle.
module odd_even_sorter #(
    parameter int DATA_W      = 8,
    parameter int TAG_W       = 4,
    parameter int K_NUMBERS   = 8,
    parameter int SIGNED_KEYS = 0,
    localparam int ENTRY_W    = DATA_W + TAG_W,
    localparam int PH_W       = $clog2(K_NUMBERS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [K_NUMBERS-1:0]           load_i,
    input  logic [K_NUMBERS*ENTRY_W-1:0]   writedata_i,
    output logic [K_NUMBERS*ENTRY_W-1:0]   readdata_o,
    input  logic                           start_i,
    input  logic                           descend_i,
    input  logic                           abort_i,
    input  logic                           irq_clr_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           aborted_o,
    output logic                           interrupt_o,
    output logic [PH_W-1:0]                phases_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   mem_q [K_NUMBERS];
    logic [ENTRY_W-1:0]   mem_d [K_NUMBERS];
    logic                 parity_q, parity_d;
    logic                 prev_clean_q, prev_clean_d;
    logic                 desc_q, desc_d;
    logic [PH_W-1:0]      phases_q, phases_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 irq_q, irq_d;
    logic                 swapped;

    function automatic logic key_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED_KEYS != 0)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        parity_d     = parity_q;
        prev_clean_d = prev_clean_q;
        desc_d       = desc_q;
        phases_d     = phases_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        irq_d        = irq_clr_i ? 1'b0 : irq_q;
        swapped      = 1'b0;

        case (state_q)
            IDLE: begin
                for (int i = 0; i < K_NUMBERS; i++) begin
                    if (load_i[i])
                        mem_d[i] = writedata_i[i*ENTRY_W +: ENTRY_W];
                end
                if (start_i && !abort_i) begin
                    state_d      = RUN;
                    desc_d       = descend_i;
                    parity_d     = 1'b0;
                    phases_d     = '0;
                    prev_clean_d = 1'b0;
                    aborted_d    = 1'b0;
                    irq_d        = 1'b0;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    // Pairs of one parity are disjoint, so every swap reads the untouched mem_q.
                    for (int j = 0; j < K_NUMBERS - 1; j++) begin
                        if ((j % 2) == int'(parity_q)) begin
                            if (desc_q ? key_gt(mem_q[j+1][ENTRY_W-1 -: DATA_W], mem_q[j][ENTRY_W-1 -: DATA_W])
                                       : key_gt(mem_q[j][ENTRY_W-1 -: DATA_W], mem_q[j+1][ENTRY_W-1 -: DATA_W])) begin
                                mem_d[j]   = mem_q[j+1];
                                mem_d[j+1] = mem_q[j];
                                swapped    = 1'b1;
                            end
                        end
                    end
                    phases_d     = phases_q + 1'b1;
                    parity_d     = ~parity_q;
                    prev_clean_d = ~swapped;
                    if ((!swapped && prev_clean_q) || (phases_d == PH_W'(K_NUMBERS))) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            parity_q     <= 1'b0;
            prev_clean_q <= 1'b0;
            desc_q       <= 1'b0;
            phases_q     <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            parity_q     <= parity_d;
            prev_clean_q <= prev_clean_d;
            desc_q       <= desc_d;
            phases_q     <= phases_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            irq_q        <= irq_d;
        end
    end

    // Array contents are undefined after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < K_NUMBERS; i++)
            mem_q[i] <= mem_d[i];
    end

    for (genvar g = 0; g < K_NUMBERS; g++) begin : g_rd
        assign readdata_o[g*ENTRY_W +: ENTRY_W] = mem_q[g];
    end

    assign busy_o      = (state_q == RUN);
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign interrupt_o = irq_q;
    assign phases_o    = phases_q;

endmodule

// File: tb/tb_odd_even_sorter.sv
// Scoreboarded bench: unsigned and signed sorter instances share stimulus; a stable reference sort predicts results.
module tb_odd_even_sorter;

    localparam int K  = 8;
    localparam int EW = 12;
    localparam int W  = K * EW;

    logic          clk = 1'b0;
    logic          rst;
    logic [K-1:0]  load;
    logic [W-1:0]  wdata;
    logic          start, descend, abort, irq_clr;
    logic [W-1:0]  u_rd, s_rd;
    logic          u_busy, u_done, u_abt, u_irq;
    logic          s_busy, s_done, s_abt, s_irq;
    logic [3:0]    u_ph, s_ph;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] keys_m [K];
    logic [3:0] tags_m [K];
    logic [W-1:0] q_u [$];
    logic [W-1:0] q_s [$];

    always #5 clk = ~clk;

    odd_even_sorter #(.DATA_W(8), .TAG_W(4), .K_NUMBERS(K), .SIGNED_KEYS(0)) u_dut (
        .clk(clk), .rst(rst), .load_i(load), .writedata_i(wdata), .readdata_o(u_rd),
        .start_i(start), .descend_i(descend), .abort_i(abort), .irq_clr_i(irq_clr),
        .busy_o(u_busy), .done_o(u_done), .aborted_o(u_abt), .interrupt_o(u_irq), .phases_o(u_ph));

    odd_even_sorter #(.DATA_W(8), .TAG_W(4), .K_NUMBERS(K), .SIGNED_KEYS(1)) s_dut (
        .clk(clk), .rst(rst), .load_i(load), .writedata_i(wdata), .readdata_o(s_rd),
        .start_i(start), .descend_i(descend), .abort_i(abort), .irq_clr_i(irq_clr),
        .busy_o(s_busy), .done_o(s_done), .aborted_o(s_abt), .interrupt_o(s_irq), .phases_o(s_ph));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit goes_first(input logic [7:0] a, input logic [7:0] b, input bit desc, input bit sgn);
        int ia, ib;
        ia = sgn ? int'({{24{a[7]}}, a}) : int'({24'b0, a});
        ib = sgn ? int'({{24{b[7]}}, b}) : int'({24'b0, b});
        return desc ? (ia > ib) : (ia < ib);
    endfunction

    function automatic logic [W-1:0] ref_sort(input bit desc, input bit sgn);
        logic [7:0] k [K];
        logic [3:0] t [K];
        logic [7:0] kk;
        logic [3:0] tt;
        logic [W-1:0] r;
        int j;
        for (int i = 0; i < K; i++) begin
            k[i] = keys_m[i];
            t[i] = tags_m[i];
        end
        for (int i = 1; i < K; i++) begin
            kk = k[i];
            tt = t[i];
            j  = i;
            while (j > 0 && goes_first(kk, k[j-1], desc, sgn)) begin
                k[j] = k[j-1];
                t[j] = t[j-1];
                j--;
            end
            k[j] = kk;
            t[j] = tt;
        end
        for (int i = 0; i < K; i++)
            r[i*EW +: EW] = {k[i], t[i]};
        return r;
    endfunction

    function automatic logic [W-1:0] pack_model();
        logic [W-1:0] r;
        for (int i = 0; i < K; i++)
            r[i*EW +: EW] = {keys_m[i], tags_m[i]};
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && u_done) begin
            if (q_u.size() == 0) check("u_unexpected_done", 1, 0);
            else check("u_sorted", u_rd, q_u.pop_front());
        end
        if (!rst && s_done) begin
            if (q_s.size() == 0) check("s_unexpected_done", 1, 0);
            else check("s_sorted", s_rd, q_s.pop_front());
        end
    end

    // Load the model contents and start in the same cycle; returns at the negedge after E0.
    task automatic kick(input bit desc, input bit push);
        @(negedge clk);
        wdata   = pack_model();
        load    = '1;
        start   = 1'b1;
        descend = desc;
        if (push) begin
            q_u.push_back(ref_sort(desc, 1'b0));
            q_s.push_back(ref_sort(desc, 1'b1));
        end
        @(posedge clk);
        @(negedge clk);
        load  = '0;
        start = 1'b0;
        check("busy_after_start", u_busy, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (u_done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
        for (int i = 0; i < 40 && s_busy; i++) @(negedge clk);
        check("s_idle", s_busy, 0);
    endtask

    int lat;

    initial begin
        rst = 1'b1; load = '0; wdata = '0; start = 1'b0; descend = 1'b0; abort = 1'b0; irq_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", u_busy, 0);
        check("rst_done", u_done, 0);
        check("rst_aborted", u_abt, 0);
        check("rst_irq", u_irq, 0);
        check("rst_phases", u_ph, 0);

        // Reversed input, worst case
        for (int i = 0; i < K; i++) begin
            keys_m[i] = 8'(7 - i);
            tags_m[i] = 4'(7 - i) ^ 4'hA;
        end
        kick(1'b0, 1'b1);
        wait_done(lat);
        check("rev_latency", lat, 8);
        check("rev_phases", u_ph, 8);
        check("rev_busy", u_busy, 0);
        check("rev_irq", u_irq, 1);
        @(negedge clk);
        check("rev_done_pulse", u_done, 0);

        // Presorted input terminates after two clean phases
        for (int i = 0; i < K; i++) begin
            keys_m[i] = 8'(i + 1);
            tags_m[i] = 4'(i);
        end
        kick(1'b0, 1'b1);
        check("pre_irq_cleared_by_start", u_irq, 0);
        wait_done(lat);
        check("pre_latency", lat, 2);
        check("pre_phases", u_ph, 2);
        check("pre_unchanged", u_rd, pack_model());
        repeat (3) @(negedge clk);
        check("pre_irq_sticky", u_irq, 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("pre_irq_clr", u_irq, 0);

        // Stability with duplicate keys, descending
        keys_m[0] = 8'd5; tags_m[0] = 4'hA;
        keys_m[1] = 8'd3; tags_m[1] = 4'hB;
        keys_m[2] = 8'd5; tags_m[2] = 4'hC;
        for (int i = 3; i < K; i++) begin
            keys_m[i] = 8'd0;
            tags_m[i] = 4'(i - 3);
        end
        kick(1'b1, 1'b1);
        wait_done(lat);
        check("dup_slot0", u_rd[0*EW +: EW], 12'h05A);
        check("dup_slot1", u_rd[1*EW +: EW], 12'h05C);
        check("dup_slot2", u_rd[2*EW +: EW], 12'h03B);

        // Signed vs unsigned ordering
        keys_m[0] = 8'h80; tags_m[0] = 4'h1;
        keys_m[1] = 8'h7F; tags_m[1] = 4'h2;
        keys_m[2] = 8'h00; tags_m[2] = 4'h3;
        for (int i = 3; i < K; i++) begin
            keys_m[i] = 8'h7F;
            tags_m[i] = 4'(i + 5);
        end
        kick(1'b0, 1'b1);
        wait_done(lat);
        check("uns_slot0", u_rd[0*EW +: EW], 12'h003);
        check("uns_slot7", u_rd[7*EW +: EW], 12'h801);
        check("sgn_slot0", s_rd[0*EW +: EW], 12'h801);
        check("sgn_slot1", s_rd[1*EW +: EW], 12'h003);
        check("sgn_slot2", s_rd[2*EW +: EW], 12'h7F2);

        // Abort at E3 with ignored load/start during the run
        for (int i = 0; i < K; i++) begin
            keys_m[i] = 8'(7 - i);
            tags_m[i] = 4'(7 - i) ^ 4'h5;
        end
        kick(1'b0, 1'b0);
        @(negedge clk);
        load  = '1;
        wdata = '0;
        start = 1'b1;
        @(negedge clk);
        load  = '0;
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abt_busy", u_busy, 0);
        check("abt_aborted", u_abt, 1);
        check("abt_done", u_done, 0);
        check("abt_irq", u_irq, 0);
        check("abt_phases", u_ph, 2);
        keys_m[0] = 6; keys_m[1] = 4; keys_m[2] = 7; keys_m[3] = 2;
        keys_m[4] = 5; keys_m[5] = 0; keys_m[6] = 3; keys_m[7] = 1;
        for (int i = 0; i < K; i++) tags_m[i] = 4'(keys_m[i]) ^ 4'h5;
        check("abt_partial", u_rd, pack_model());
        repeat (12) @(negedge clk);
        check("abt_no_irq_later", u_irq, 0);

        // Reset in the middle of a run
        for (int i = 0; i < K; i++) begin
            keys_m[i] = 8'(7 - i);
            tags_m[i] = 4'(i);
        end
        kick(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", u_busy, 0);
        check("mid_rst_phases", u_ph, 0);
        check("mid_rst_aborted", u_abt, 0);
        check("mid_rst_irq", u_irq, 0);
        check("mid_rst_done", u_done, 0);

        // start together with abort while idle is refused
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", u_busy, 0);
        repeat (10) @(negedge clk);
        check("start_abort_phases", u_ph, 0);

        check("q_u_drained", q_u.size(), 0);
        check("q_s_drained", q_s.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
